approx_mul_seq: RTL and testbench

Parametrised, sequential, column-truncated approximate unsigned multiplier for the error-evaluation benchmark set. It generalises the fixed 6x6 combinational truncated multipliers to any operand width and truncation depth. It computes the product over WIDTH cycles with shift-add iteration behind valid/ready handshakes, so error-characterisation benches can stream operand pairs through it.

---
 rtl/approx_mul_seq.sv | 180 ++++++++++++++++++
 tb/tb_approx_mul_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_seq.sv
// approx_mul_seq: sequential column-truncated approximate unsigned multiplier.
// One shift-add step per cycle over WIDTH cycles, valid/ready on both sides.
// Partial product a[i]&b[j] is kept only when i+j >= TRUNC (TRUNC=0 is exact).
// Optional feature macro: APPROX_MUL_ERRDIST_EN adds an exact accumulator and
// the err_dist output (exact minus approximate product).
module approx_mul_seq #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned TRUNC = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
`ifdef APPROX_MUL_ERRDIST_EN
    ,
    output logic [2*WIDTH-1:0]   err_dist
`endif
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned LAST  = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [PW-1:0]      acc;
    logic [CNT_W-1:0]   cnt;

    logic               last_c;
    logic [WIDTH-1:0]   mask_c;
    logic [PW-1:0]      addend_c;
    logic [PW-1:0]      acc_nxt_c;
    logic               in_ready_nxt_c;
    logic               out_valid_nxt_c;
    logic               load_c;
    logic               accept_c;

    assign last_c   = (cnt == CNT_W'(LAST));
    assign accept_c = (state == S_IDLE) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)  state_nxt = S_BUSY;
            S_BUSY:  if (last_c)    state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered handshake outputs
    always_comb begin
        in_ready_nxt_c  = 1'b0;
        out_valid_nxt_c = 1'b0;
        load_c          = 1'b0;
        case (state_nxt)
            S_IDLE:  in_ready_nxt_c  = 1'b1;
            S_DONE:  out_valid_nxt_c = 1'b1;
            default: ;
        endcase
        if ((state == S_BUSY) && last_c) begin
            load_c = 1'b1;
        end
    end

    // Column mask for the current shift: keep bit i when column i+cnt survives truncation
    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            mask_c[i] = (i + 32'(cnt) + 32'd1) > TRUNC;
        end
    end

    // Masked, shifted partial-product row selected by the current multiplier bit
    always_comb begin
        addend_c  = '0;
        if (b_r[cnt]) begin
            addend_c = PW'(a_r & mask_c) << cnt;
        end
        acc_nxt_c = acc + addend_c;
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt_c;
            out_valid <= out_valid_nxt_c;
        end
    end

    // Operand capture, accumulation and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (accept_c) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            cnt <= '0;
        end else if (state == S_BUSY) begin
            acc <= acc_nxt_c;
            if (!last_c) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Result register: loaded on the final add, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (load_c) begin
            product <= acc_nxt_c;
        end
    end

`ifdef APPROX_MUL_ERRDIST_EN
    logic [PW-1:0] exact_acc;
    logic [PW-1:0] exact_nxt_c;

    // Unmasked row for the exact reference sum
    always_comb begin
        exact_nxt_c = exact_acc;
        if (b_r[cnt]) begin
            exact_nxt_c = exact_acc + (PW'(a_r) << cnt);
        end
    end

    // Exact accumulator, stepped alongside the approximate one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact_acc <= '0;
        end else if (accept_c) begin
            exact_acc <= '0;
        end else if (state == S_BUSY) begin
            exact_acc <= exact_nxt_c;
        end
    end

    // Error distance, loaded together with product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_dist <= '0;
        end else if (load_c) begin
            err_dist <= exact_nxt_c - acc_nxt_c;
        end
    end
`endif

endmodule

// File: tb/tb_approx_mul_seq.sv
// Bench for approx_mul_seq: three instances (6/5, 6/0, 8/7) share clock,
// reset, operands and out_ready; in_valid is steered to the selected one.
module tb_approx_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv;
    logic        ordy;
    logic [7:0]  a_d;
    logic [7:0]  b_d;
    int          cur;

    int checks   = 0;
    int failures = 0;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [11:0] p0, p1;
    logic [15:0] p2;

    logic        rdy_m;
    logic        ov_m;
    logic [15:0] prod_m;
    logic [15:0] err_m;

`ifdef APPROX_MUL_ERRDIST_EN
    logic [11:0] e0, e1;
    logic [15:0] e2;
`endif

    always #5 clk = ~clk;

    approx_mul_seq #(.WIDTH(6), .TRUNC(5)) u6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv && (cur == 0)),
        .in_ready  (rdy0),
        .a         (a_d[5:0]),
        .b         (b_d[5:0]),
        .out_valid (ov0),
        .out_ready (ordy),
        .product   (p0)
`ifdef APPROX_MUL_ERRDIST_EN
        ,
        .err_dist  (e0)
`endif
    );

    approx_mul_seq #(.WIDTH(6), .TRUNC(0)) u6x (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv && (cur == 1)),
        .in_ready  (rdy1),
        .a         (a_d[5:0]),
        .b         (b_d[5:0]),
        .out_valid (ov1),
        .out_ready (ordy),
        .product   (p1)
`ifdef APPROX_MUL_ERRDIST_EN
        ,
        .err_dist  (e1)
`endif
    );

    approx_mul_seq #(.WIDTH(8), .TRUNC(7)) u8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv && (cur == 2)),
        .in_ready  (rdy2),
        .a         (a_d),
        .b         (b_d),
        .out_valid (ov2),
        .out_ready (ordy),
        .product   (p2)
`ifdef APPROX_MUL_ERRDIST_EN
        ,
        .err_dist  (e2)
`endif
    );

    // Steer observation to the selected instance
    always_comb begin
        rdy_m  = rdy0;
        ov_m   = ov0;
        prod_m = 16'(p0);
        err_m  = '0;
        if (cur == 1) begin
            rdy_m = rdy1; ov_m = ov1; prod_m = 16'(p1);
        end else if (cur == 2) begin
            rdy_m = rdy2; ov_m = ov2; prod_m = p2;
        end
`ifdef APPROX_MUL_ERRDIST_EN
        err_m = (cur == 0) ? 16'(e0) : (cur == 1) ? 16'(e1) : e2;
`endif
    end

    // Reference: sum of 2^(i+j) over set bit pairs whose column survives truncation
    function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y,
                                             input int w, input int t);
        int unsigned s = 0;
        for (int i = 0; i < w; i++)
            for (int j = 0; j < w; j++)
                if (x[i] && y[j] && (i + j >= t)) s += 32'd1 << (i + j);
        return 16'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction; entered and left at a falling edge
    task automatic do_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                         input int stall, input int w,
                         output logic [15:0] p, output logic [15:0] e);
        int n;
        cur  = sel;
        a_d  = av;
        b_d  = bv;
        iv   = 1'b1;
        ordy = (stall == 0);
        n = 0;
        while (!rdy_m && n < 50) begin @(negedge clk); n++; end
        check("accept_timeout", 32'(n < 50), 32'd1);
        @(negedge clk);
        iv  = 1'b0;
        a_d = 8'($urandom);
        b_d = 8'($urandom);
        n = 0;
        while (!ov_m && n < 40) begin
            if (rdy_m) check("busy_in_ready", 32'(rdy_m), 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(w));
        p = prod_m;
        e = err_m;
        if (stall > 0) begin
            iv = 1'b1;
            for (int s = 0; s < stall; s++) begin
                check("hold_out_valid", 32'(ov_m), 32'd1);
                check("hold_in_ready", 32'(rdy_m), 32'd0);
                check("hold_product", 32'(prod_m), 32'(p));
                a_d = 8'($urandom);
                b_d = 8'($urandom);
                @(negedge clk);
            end
            iv   = 1'b0;
            ordy = 1'b1;
        end
        @(negedge clk);
        check("out_valid_drop", 32'(ov_m), 32'd0);
        check("in_ready_return", 32'(rdy_m), 32'd1);
        ordy = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic [15:0] e;
    } dir_t;

    initial begin
        dir_t        dirs[3];
        logic [15:0] p, e, exp_p;
        logic [7:0]  ra, rb;
        int          hits;

        dirs[0] = '{a: 8'd63, b: 8'd63, p: 16'd3840, e: 16'd129};
        dirs[1] = '{a: 8'd3,  b: 8'd3,  p: 16'd0,    e: 16'd9};
        dirs[2] = '{a: 8'd32, b: 8'd1,  p: 16'd32,   e: 16'd0};

        rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; a_d = '0; b_d = '0; cur = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(rdy0), 32'd1);
        check("rst_out_valid", 32'(ov0), 32'd0);
        check("rst_product", 32'(p0), 32'd0);
`ifdef APPROX_MUL_ERRDIST_EN
        check("rst_err_dist", 32'(e0), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases on the 6x6, TRUNC=5 instance
        foreach (dirs[k]) begin
            do_op(0, dirs[k].a, dirs[k].b, 0, 6, p, e);
            check("dir_product", 32'(p), 32'(dirs[k].p));
            check("dir_model", 32'(p), 32'(ref_prod(dirs[k].a, dirs[k].b, 6, 5)));
`ifdef APPROX_MUL_ERRDIST_EN
            check("dir_err_dist", 32'(e), 32'(dirs[k].e));
`endif
        end

        // Back-pressure: 10 stalled cycles in DONE, inputs offered and ignored
        do_op(0, 8'd63, 8'd63, 10, 6, p, e);
        check("stall_product", 32'(p), 32'd3840);

        // Reset during BUSY aborts with no later out_valid
        cur = 0; a_d = 8'd10; b_d = 8'd60; iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(ov0), 32'd0);
        check("abort_in_ready", 32'(rdy0), 32'd1);
        check("abort_product", 32'(p0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            if (ov0) hits++;
            @(negedge clk);
        end
        check("abort_no_out_valid", 32'(hits), 32'd0);
        do_op(0, 8'd5, 8'd7, 0, 6, p, e);
        check("post_abort_model", 32'(p), 32'(ref_prod(8'd5, 8'd7, 6, 5)));
        check("post_abort_product", 32'(p), 32'd0);

        // Exhaustive exact sweep on the TRUNC=0 instance
        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                do_op(1, 8'(x), 8'(y), 0, 6, p, e);
                check("exact_product", 32'(p), 32'(x * y));
`ifdef APPROX_MUL_ERRDIST_EN
                check("exact_err_dist", 32'(e), 32'd0);
`endif
            end
        end

        // Random sweep with back-pressure on the 8x8, TRUNC=7 instance
        for (int k = 0; k < 2000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (k == 0) begin ra = 8'd255; rb = 8'd255; end
            exp_p = ref_prod(ra, rb, 8, 7);
            do_op(2, ra, rb, int'($urandom_range(0, 2)), 8, p, e);
            check("rand_product", 32'(p), 32'(exp_p));
            check("rand_le_exact", 32'(p <= 16'(ra) * 16'(rb)), 32'd1);
            check("rand_low_zero", 32'(p[6:0]), 32'd0);
`ifdef APPROX_MUL_ERRDIST_EN
            check("rand_err_dist", 32'(e), 32'(16'(ra) * 16'(rb) - exp_p));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
